// File: rtl/epu_layer_sched.sv
`timescale 1ns/1ps
// epu_layer_sched
//   Queues layer commands for the ConvAcc engine and dispatches them one at a
//   time. Each layer holds conv_start_o high until the engine reports finish.
//   After that, start stays low for at least two cycles before the next layer.
//
//   Optional feature: define EPU_SCHED_WDT_EN to add a per-layer watchdog.
//   The watchdog ends a hung layer after TO_CYC busy cycles and flags err_o.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   cmd_valid_i/ready_o   command handshake into the DEPTH-entry FIFO
//   cmd_mode_i/w8_i/      per-layer config: mode, weight word, transpose,
//   cmd_trans_i/last_i      interrupt-on-finish
//   run_i                 dispatch enable (level)
//   abort_i               flush FIFO and return to idle
//   conv_start_o          start level to ConvAcc
//   conv_mode_o/w8_o,     config of the active (or most recent) layer
//   inout_trans_o
//   conv_fin_i            finish pulse from ConvAcc
//   irq_o / err_o         sticky interrupt / watchdog error
//   irq_clr_i             clears irq_o and err_o
//   busy_o                layer in progress (BUSY or GAP)
//   done_cnt_o            completed-layer count, wraps at 255
//   fifo_cnt_o            FIFO occupancy
module epu_layer_sched #(
    parameter int          DEPTH  = 4,
    parameter logic [23:0] TO_CYC = 24'hFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [3:0]               cmd_mode_i,
    input  logic [31:0]              cmd_w8_i,
    input  logic                     cmd_trans_i,
    input  logic                     cmd_last_i,
    input  logic                     run_i,
    input  logic                     abort_i,
    output logic                     conv_start_o,
    output logic [3:0]               conv_mode_o,
    output logic [31:0]              conv_w8_o,
    output logic                     inout_trans_o,
    input  logic                     conv_fin_i,
    output logic                     irq_o,
    input  logic                     irq_clr_i,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [7:0]               done_cnt_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t state, state_nxt;

    // FIFO entry layout: {mode[37:34], w8[33:2], trans[1], last[0]}
    logic [37:0]   mem [DEPTH];
    logic [37:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          last_q;
    logic          push, pop, fin_ok, wdt_expire, irq_set;

    assign cmd_ready_o = (cnt < DEPTH_C);
    assign fifo_cnt_o  = cnt;
    assign head        = mem[rd_ptr];

    // A command offered in the abort cycle is discarded with the flush.
    assign push   = cmd_valid_i & cmd_ready_o & ~abort_i;
    // Pop uses the registered count, so a push into an empty FIFO is
    // dispatched no earlier than the following cycle.
    assign pop    = (state == S_IDLE) & run_i & (cnt != '0) & ~abort_i;
    assign fin_ok = (state == S_BUSY) & conv_fin_i & ~abort_i;

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_mode_i, cmd_w8_i, cmd_trans_i, cmd_last_i};
    end

    // ---------------- optional watchdog ----------------
`ifdef EPU_SCHED_WDT_EN
    logic [23:0] wdt_cnt;
    logic        err_q;

    // wdt_cnt is the number of BUSY cycles already completed, so expiry
    // fires in the TO_CYC-th BUSY cycle and start drops right after it.
    always_ff @(posedge clk) begin
        if (!rst)                 wdt_cnt <= '0;
        else if (pop)             wdt_cnt <= '0;
        else if (state == S_BUSY) wdt_cnt <= wdt_cnt + 24'd1;
    end

    assign wdt_expire = (state == S_BUSY) & ~conv_fin_i & ~abort_i &
                        (wdt_cnt == TO_CYC - 24'd1);

    always_ff @(posedge clk) begin
        if (!rst)           err_q <= 1'b0;
        else if (wdt_expire) err_q <= 1'b1;
        else if (irq_clr_i)  err_q <= 1'b0;
    end
    assign err_o = err_q;
`else
    // No watchdog: BUSY waits for conv_fin_i indefinitely.
    assign wdt_expire = 1'b0 & (TO_CYC != 24'd0);
    assign err_o      = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_BUSY;
            S_BUSY:  if (fin_ok | wdt_expire) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_i) state_nxt = S_IDLE;
    end

    always_comb begin
        conv_start_o = 1'b0;
        busy_o       = 1'b0;
        case (state)
            S_BUSY: begin
                conv_start_o = 1'b1;
                busy_o       = 1'b1;
            end
            S_GAP:   busy_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------- active-layer config ----------------
    // Loaded only on pop; held through BUSY, GAP, IDLE and abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_mode_o   <= 4'h1;
            conv_w8_o     <= '0;
            inout_trans_o <= 1'b0;
            last_q        <= 1'b0;
        end else if (pop) begin
            conv_mode_o   <= head[37:34];
            conv_w8_o     <= head[33:2];
            inout_trans_o <= head[1];
            last_q        <= head[0];
        end
    end

    // ---------------- completion count and interrupt ----------------
    always_ff @(posedge clk) begin
        if (!rst)        done_cnt_o <= '0;
        else if (fin_ok) done_cnt_o <= done_cnt_o + 8'd1;
    end

    // If set and clear arrive together, the set wins.
    assign irq_set = (fin_ok & last_q) | wdt_expire;

    always_ff @(posedge clk) begin
        if (!rst)           irq_o <= 1'b0;
        else if (irq_set)   irq_o <= 1'b1;
        else if (irq_clr_i) irq_o <= 1'b0;
    end

endmodule

// File: tb/tb_epu_layer_sched.sv
`timescale 1ns/1ps
module tb_epu_layer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o;
    logic [3:0]  cmd_mode_i;
    logic [31:0] cmd_w8_i;
    logic        cmd_trans_i, cmd_last_i;
    logic        run_i, abort_i;
    logic        conv_start_o;
    logic [3:0]  conv_mode_o;
    logic [31:0] conv_w8_o;
    logic        inout_trans_o;
    logic        conv_fin_i;
    logic        irq_o, irq_clr_i, err_o, busy_o;
    logic [7:0]  done_cnt_o;
    logic [2:0]  fifo_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    epu_layer_sched #(.DEPTH(4), .TO_CYC(24'd20)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mode_i(cmd_mode_i), .cmd_w8_i(cmd_w8_i),
        .cmd_trans_i(cmd_trans_i), .cmd_last_i(cmd_last_i),
        .run_i(run_i), .abort_i(abort_i),
        .conv_start_o(conv_start_o), .conv_mode_o(conv_mode_o),
        .conv_w8_o(conv_w8_o), .inout_trans_o(inout_trans_o),
        .conv_fin_i(conv_fin_i), .irq_o(irq_o), .irq_clr_i(irq_clr_i),
        .err_o(err_o), .busy_o(busy_o),
        .done_cnt_o(done_cnt_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [31:0] w,
                        input logic t, input logic l);
        cmd_valid_i = 1'b1;
        cmd_mode_i  = m;
        cmd_w8_i    = w;
        cmd_trans_i = t;
        cmd_last_i  = l;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // n = cycles spent waiting with start low
    task automatic wait_start(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            if (conv_start_o) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic pulse_fin();
        conv_fin_i = 1'b1;
        tick();
        conv_fin_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready_o); end
        checks++; if (conv_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", conv_start_o); end
        checks++; if (conv_mode_o !== 4'h1) begin errors++; $display("FAIL reset_mode got %h exp 1", conv_mode_o); end
        checks++; if (conv_w8_o !== 32'h0 || inout_trans_o !== 1'b0) begin errors++; $display("FAIL reset_cfg got w8 %h tr %b exp 0 0", conv_w8_o, inout_trans_o); end
        checks++; if (irq_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_flags got irq %b err %b busy %b exp 000", irq_o, err_o, busy_o); end
        checks++; if (done_cnt_o !== 8'd0 || fifo_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_counts got done %0d fifo %0d exp 0 0", done_cnt_o, fifo_cnt_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fifo_full();
        bit ok; int n;
        run_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'(4 + i), 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 3) begin
                checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", cmd_ready_o); end
            end
        end
        checks++; if (fifo_cnt_o !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", fifo_cnt_o); end
        // Drain: only the first four modes may appear, the fifth was refused.
        run_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(ok, n);
            checks++; if (!ok || conv_mode_o !== 4'(4 + k)) begin errors++; $display("FAIL full_drain%0d got start %b mode %0d exp 1 %0d", k, ok, conv_mode_o, 4 + k); end
            pulse_fin();
            exp_done++;
        end
        tick(); tick(); tick();
        checks++; if (busy_o !== 1'b0 || fifo_cnt_o !== 3'd0 || done_cnt_o !== 8'(exp_done)) begin errors++; $display("FAIL full_after got busy %b fifo %0d done %0d exp 0 0 %0d", busy_o, fifo_cnt_o, done_cnt_o, exp_done); end
        run_i = 1'b0;
    endtask

    task automatic test_sequence();
        bit ok; int n;
        logic [31:0] w8s [3];
        w8s[0] = 32'hA000_0001; w8s[1] = 32'hB000_0002; w8s[2] = 32'hC000_0003;
        run_i = 1'b0;
        push(4'd1, w8s[0], 1'b1, 1'b0);
        push(4'd2, w8s[1], 1'b0, 1'b0);
        push(4'd3, w8s[2], 1'b1, 1'b1);
        checks++; if (fifo_cnt_o !== 3'd3) begin errors++; $display("FAIL seq_cnt got %0d exp 3", fifo_cnt_o); end
        run_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start(ok, n);
            checks++; if (!ok || conv_mode_o !== 4'(k + 1) || conv_w8_o !== w8s[k] || inout_trans_o !== (k != 1)) begin
                errors++; $display("FAIL seq_cfg%0d got ok %b mode %0d w8 %h tr %b exp mode %0d w8 %h", k, ok, conv_mode_o, conv_w8_o, inout_trans_o, k + 1, w8s[k]);
            end
            if (k == 0) begin
                checks++; if (n !== 1) begin errors++; $display("FAIL seq_latency got %0d exp 1", n); end
            end else begin
                checks++; if (n !== 2) begin errors++; $display("FAIL seq_gap%0d got %0d exp 2", k, n); end
            end
            checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL seq_irq_early%0d got %b exp 0", k, irq_o); end
            repeat (9) tick();
            checks++; if (conv_start_o !== 1'b1) begin errors++; $display("FAIL seq_hold%0d got %b exp 1", k, conv_start_o); end
            pulse_fin();
            exp_done++;
            checks++; if (conv_start_o !== 1'b0 || busy_o !== 1'b1 || done_cnt_o !== 8'(exp_done)) begin
                errors++; $display("FAIL seq_fin%0d got start %b busy %b done %0d exp 0 1 %0d", k, conv_start_o, busy_o, done_cnt_o, exp_done);
            end
            checks++; if (irq_o !== (k == 2) || conv_mode_o !== 4'(k + 1)) begin errors++; $display("FAIL seq_irq%0d got irq %b mode %0d exp %b %0d", k, irq_o, conv_mode_o, k == 2, k + 1); end
        end
        run_i = 1'b0;
        tick();
    endtask

    task automatic test_fin_ignored();
        pulse_fin();
        tick();
        checks++; if (done_cnt_o !== 8'(exp_done) || busy_o !== 1'b0 || irq_o !== 1'b1) begin
            errors++; $display("FAIL fin_idle got done %0d busy %b irq %b exp %0d 0 1", done_cnt_o, busy_o, irq_o, exp_done);
        end
    endtask

    task automatic test_abort();
        bit ok; int n;
        run_i = 1'b0;
        push(4'd9, 32'h9, 1'b1, 1'b0);
        push(4'd10, 32'hA, 1'b0, 1'b0);
        push(4'd11, 32'hB, 1'b0, 1'b0);
        run_i = 1'b1;
        wait_start(ok, n);
        checks++; if (!ok || fifo_cnt_o !== 3'd2) begin errors++; $display("FAIL abort_pre got start %b fifo %0d exp 1 2", ok, fifo_cnt_o); end
        abort_i     = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_mode_i  = 4'd12;
        tick();
        abort_i     = 1'b0;
        cmd_valid_i = 1'b0;
        checks++; if (fifo_cnt_o !== 3'd0 || conv_start_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_flush got fifo %0d start %b busy %b exp 0 0 0", fifo_cnt_o, conv_start_o, busy_o);
        end
        checks++; if (done_cnt_o !== 8'(exp_done) || conv_mode_o !== 4'd9 || irq_o !== 1'b1) begin
            errors++; $display("FAIL abort_keep got done %0d mode %0d irq %b exp %0d 9 1", done_cnt_o, conv_mode_o, irq_o, exp_done);
        end
        tick(); tick();
        checks++; if (conv_start_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin errors++; $display("FAIL abort_stay got start %b fifo %0d exp 0 0", conv_start_o, fifo_cnt_o); end
        run_i = 1'b0;
    endtask

    task automatic test_irq_clr();
        bit ok; int n;
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL clr_idle got %b exp 0", irq_o); end
        run_i = 1'b1;
        push(4'd5, 32'h55, 1'b0, 1'b1);
        wait_start(ok, n);
        conv_fin_i = 1'b1;
        irq_clr_i  = 1'b1;
        tick();
        conv_fin_i = 1'b0;
        irq_clr_i  = 1'b0;
        exp_done++;
        checks++; if (!ok || irq_o !== 1'b1 || done_cnt_o !== 8'(exp_done)) begin
            errors++; $display("FAIL clr_setwins got ok %b irq %b done %0d exp 1 1 %0d", ok, irq_o, done_cnt_o, exp_done);
        end
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL clr_next got %b exp 0", irq_o); end
        run_i = 1'b0;
        tick();
    endtask

    task automatic test_run_low();
        bit ok; int n;
        run_i = 1'b1;
        push(4'd6, 32'h66, 1'b0, 1'b0);
        wait_start(ok, n);
        run_i = 1'b0;
        tick(); tick(); tick();
        checks++; if (!ok || conv_start_o !== 1'b1) begin errors++; $display("FAIL runlow_hold got ok %b start %b exp 1 1", ok, conv_start_o); end
        pulse_fin();
        exp_done++;
        checks++; if (done_cnt_o !== 8'(exp_done) || busy_o !== 1'b1) begin errors++; $display("FAIL runlow_fin got done %0d busy %b exp %0d 1", done_cnt_o, busy_o, exp_done); end
        tick();
    endtask

    task automatic test_wdt();
        bit ok; int n; int hi;
        run_i = 1'b1;
        push(4'd7, 32'h77, 1'b0, 1'b0);
        wait_start(ok, n);
        hi = 0;
        while (conv_start_o && hi < 40) begin
            hi++;
            tick();
        end
`ifdef EPU_SCHED_WDT_EN
        checks++; if (hi !== 20) begin errors++; $display("FAIL wdt_len got %0d exp 20", hi); end
        checks++; if (err_o !== 1'b1 || irq_o !== 1'b1 || done_cnt_o !== 8'(exp_done)) begin
            errors++; $display("FAIL wdt_flags got err %b irq %b done %0d exp 1 1 %0d", err_o, irq_o, done_cnt_o, exp_done);
        end
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        checks++; if (err_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL wdt_clr got err %b irq %b exp 0 0", err_o, irq_o); end
        push(4'd8, 32'h88, 1'b0, 1'b0);
        wait_start(ok, n);
        checks++; if (!ok || conv_mode_o !== 4'd8) begin errors++; $display("FAIL wdt_next got ok %b mode %0d exp 1 8", ok, conv_mode_o); end
`else
        checks++; if (!ok || hi !== 40 || err_o !== 1'b0) begin errors++; $display("FAIL nowdt_wait got ok %b len %0d err %b exp 1 40 0", ok, hi, err_o); end
`endif
        pulse_fin();
        exp_done++;
        checks++; if (done_cnt_o !== 8'(exp_done)) begin errors++; $display("FAIL wdt_done got %0d exp %0d", done_cnt_o, exp_done); end
        run_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok; int n;
        run_i = 1'b0;
        push(4'd2, 32'h22, 1'b1, 1'b0);
        push(4'd3, 32'h33, 1'b0, 1'b0);
        run_i = 1'b1;
        wait_start(ok, n);
        rst = 1'b0;
        tick();
        checks++; if (!ok || conv_start_o !== 1'b0 || fifo_cnt_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rstmid got ok %b start %b fifo %0d busy %b exp 1 0 0 0", ok, conv_start_o, fifo_cnt_o, busy_o);
        end
        checks++; if (done_cnt_o !== 8'd0 || conv_mode_o !== 4'h1) begin errors++; $display("FAIL rstmid_regs got done %0d mode %0d exp 0 1", done_cnt_o, conv_mode_o); end
        rst = 1'b1;
        exp_done = 0;
        tick(); tick();
        checks++; if (conv_start_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin errors++; $display("FAIL rstmid_after got start %b fifo %0d exp 0 0", conv_start_o, fifo_cnt_o); end
        run_i = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok; int n; bit bad;
        bad   = 1'b0;
        run_i = 1'b1;
        for (int i = 0; i < 255; i++) begin
            push(4'd1, 32'(i), 1'b0, 1'b0);
            wait_start(ok, n);
            if (!ok) begin
                bad = 1'b1;
                break;
            end
            pulse_fin();
            exp_done++;
        end
        checks++; if (bad || done_cnt_o !== 8'd255) begin errors++; $display("FAIL wrap_255 got timeout %b done %0d exp 0 255", bad, done_cnt_o); end
        push(4'd2, 32'h2, 1'b0, 1'b0);
        wait_start(ok, n);
        pulse_fin();
        checks++; if (!ok || done_cnt_o !== 8'd0) begin errors++; $display("FAIL wrap_0 got ok %b done %0d exp 1 0", ok, done_cnt_o); end
        run_i = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; cmd_valid_i = 1'b0; cmd_mode_i = '0; cmd_w8_i = '0;
        cmd_trans_i = 1'b0; cmd_last_i = 1'b0; run_i = 1'b0; abort_i = 1'b0;
        conv_fin_i = 1'b0; irq_clr_i = 1'b0;
        test_reset();
        test_fifo_full();
        test_sequence();
        test_fin_ignored();
        test_abort();
        test_irq_clr();
        test_run_low();
        test_wdt();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
